// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage RV32I pipeline: load-use stall,
// redirect flush, memory-busy freeze and registered EX forwarding selects.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_bubble,
  output logic             flush_id,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FLUSH  = 2'b01,
    FREEZE = 2'b10
  } state_t;

  state_t           state_q, state_d, saved_q, saved_d, eff_state;
  logic [2:0]       cnt_q, cnt_d;
  logic [4:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic             ex_we_q, ex_we_d, ex_load_q, ex_load_d, mem_we_q, mem_we_d;
  logic [1:0]       fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use, issue, redirect_ok;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] e_rd,
                                         input logic e_we, input logic e_ld,
                                         input logic [4:0] m_rd, input logic m_we);
    logic [1:0] s;
    s = 2'b00;
    if (rs != 5'd0) begin
      if (e_we && e_rd == rs && !e_ld) s = 2'b01;
      else if (m_we && m_rd == rs)     s = 2'b10;
    end
    return s;
  endfunction

  // Redirect is gated by reset so a held ex_redirect cannot flush during reset.
  assign redirect_ok = rst_n & ex_redirect;
  assign load_use = id_valid & ex_load_q & ex_we_q &
                    (((id_rs1 != 5'd0) && (id_rs1 == ex_rd_q)) ||
                     ((id_rs2 != 5'd0) && (id_rs2 == ex_rd_q)));

  always_comb begin
    eff_state = (state_q == FREEZE) ? saved_q : state_q;
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_bubble = 1'b0;
    flush_id  = 1'b0;
    if (mem_busy) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
      state_d  = FREEZE;
      saved_d  = eff_state;
    end else begin
      state_d = eff_state;
      if (eff_state == FLUSH) begin
        flush_id = 1'b1;
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RUN;
      end else if (redirect_ok) begin
        flush_id  = 1'b1;
        ex_bubble = 1'b1;
        if (FLUSH_CYC > 1) begin
          state_d = FLUSH;
          cnt_d   = 3'(FLUSH_CYC - 1);
        end
      end else if (load_use) begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_bubble = 1'b1;
      end
    end
    ctrl_state = mem_busy ? FREEZE : eff_state;
  end

  always_comb begin
    issue     = id_valid & ~id_stall & ~ex_bubble & ~flush_id;
    ex_rd_d   = ex_rd_q;
    ex_we_d   = ex_we_q;
    ex_load_d = ex_load_q;
    mem_rd_d  = mem_rd_q;
    mem_we_d  = mem_we_q;
    fwd1_d    = fwd1_q;
    fwd2_d    = fwd2_q;
    if (!mem_busy) begin
      mem_rd_d  = ex_rd_q;
      mem_we_d  = ex_we_q;
      ex_rd_d   = issue ? id_rd : 5'd0;
      ex_we_d   = issue & id_rd_we & (id_rd != 5'd0);
      ex_load_d = issue & id_is_load;
      fwd1_d    = issue ? fwd_sel(id_rs1, ex_rd_q, ex_we_q, ex_load_q, mem_rd_q, mem_we_q) : 2'b00;
      fwd2_d    = issue ? fwd_sel(id_rs2, ex_rd_q, ex_we_q, ex_load_q, mem_rd_q, mem_we_q) : 2'b00;
    end
    stall_d = (if_stall && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      saved_q   <= RUN;
      cnt_q     <= '0;
      ex_rd_q   <= '0;
      ex_we_q   <= 1'b0;
      ex_load_q <= 1'b0;
      mem_rd_q  <= '0;
      mem_we_q  <= 1'b0;
      fwd1_q    <= '0;
      fwd2_q    <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      cnt_q     <= cnt_d;
      ex_rd_q   <= ex_rd_d;
      ex_we_q   <= ex_we_d;
      ex_load_q <= ex_load_d;
      mem_rd_q  <= mem_rd_d;
      mem_we_q  <= mem_we_d;
      fwd1_q    <= fwd1_d;
      fwd2_q    <= fwd2_d;
      stall_q   <= stall_d;
    end
  end

  assign fwd_rs1_sel  = fwd1_q;
  assign fwd_rs2_sel  = fwd2_q;
  assign stall_cycles = stall_q;

endmodule
